instr_fetch: RTL and testbench

Instruction fetch unit for the MIPS core: the requesting end of the instruction memory interface. Holds the program counter, drives a word address into the combinational `instr_mem` each cycle, and buffers fetched words in a 2-entry queue. The queue presents instructions to decode with a valid/ready handshake. Branch/jump redirects flush the queue; a fetched `BREAK` halts fetching until the next redirect.

---
 rtl/mips_pkg.sv | 18 +
 rtl/instr_fetch_queue.sv | 79 +++++++
 rtl/instr_fetch.sv | 87 ++++++++
 tb/tb_instr_fetch.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch path.
// Holds opcode fields, the default reset PC and the fetch FSM state.
package mips_pkg;

  localparam logic [5:0]  OPC_SPECIAL      = 6'h00;
  localparam logic [5:0]  FUNCT_BREAK      = 6'h0D;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

  function automatic logic is_break(input logic [31:0] w);
    return (w[31:26] == OPC_SPECIAL) && (w[5:0] == FUNCT_BREAK);
  endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Two-entry FIFO of {instr, pc} between fetch and decode.
// Entry 0 is always the head; pops shift entry 1 down.
module fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORD   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [MEM_WORD-1:0]   in_instr,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  output logic [1:0]            count,
  output logic [MEM_WORD-1:0]   head_instr,
  output logic [ADDR_WIDTH-1:0] head_pc
);

  logic [1:0]            cnt_q, cnt_d;
  logic [MEM_WORD-1:0]   h_instr_q, h_instr_d;
  logic [ADDR_WIDTH-1:0] h_pc_q, h_pc_d;
  logic [MEM_WORD-1:0]   t_instr_q, t_instr_d;
  logic [ADDR_WIDTH-1:0] t_pc_q, t_pc_d;

  always_comb begin
    cnt_d     = cnt_q;
    h_instr_d = h_instr_q;
    h_pc_d    = h_pc_q;
    t_instr_d = t_instr_q;
    t_pc_d    = t_pc_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else if (push && pop) begin
      if (cnt_q == 2'd2) begin
        h_instr_d = t_instr_q;
        h_pc_d    = t_pc_q;
        t_instr_d = in_instr;
        t_pc_d    = in_pc;
      end else begin
        h_instr_d = in_instr;
        h_pc_d    = in_pc;
      end
    end else if (push) begin
      if (cnt_q == 2'd0) begin
        h_instr_d = in_instr;
        h_pc_d    = in_pc;
      end else begin
        t_instr_d = in_instr;
        t_pc_d    = in_pc;
      end
      cnt_d = cnt_q + 2'd1;
    end else if (pop) begin
      h_instr_d = t_instr_q;
      h_pc_d    = t_pc_q;
      cnt_d     = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      h_instr_q <= '0;
      h_pc_q    <= '0;
      t_instr_q <= '0;
      t_pc_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      h_instr_q <= h_instr_d;
      h_pc_q    <= h_pc_d;
      t_instr_q <= t_instr_d;
      t_pc_q    <= t_pc_d;
    end
  end

  assign count      = cnt_q;
  assign head_instr = h_instr_q;
  assign head_pc    = h_pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, RUN/HALT FSM, BREAK decode and
// push/pop/flush arbitration around a 2-entry fetch queue.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_WORD   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [MEM_WORD-1:0]   imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MEM_WORD-1:0]   out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  halted
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            count;
  logic                  pop, fire, brk;
  logic                  unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];
  assign imem_addr  = {2'b00, pc_q[ADDR_WIDTH-1:2]};
  assign out_valid  = (count != 2'd0);
  assign brk        = is_break(32'(imem_data));

  // A redirect suppresses both ends of the queue for its cycle.
  assign pop  = out_valid && out_ready && !redirect_valid;
  assign fire = (state_q == FS_RUN) && !redirect_valid &&
                ((count != 2'd2) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      redirect_valid: state_d = FS_RUN;
      fire && brk:    state_d = FS_HALT;
      default:        ;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redirect_valid: pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      fire:           pc_d = pc_q + ADDR_WIDTH'(4);
      default:        ;
    endcase
  end

  always_comb begin
    halted = (state_q == FS_HALT);
  end

  fetch_queue #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_WORD   (MEM_WORD)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fire),
    .pop        (pop),
    .flush      (redirect_valid),
    .in_instr   (imem_data),
    .in_pc      (pc_q),
    .count      (count),
    .head_instr (out_instr),
    .head_pc    (out_pc)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table plus
// hand-written BREAK, redirect and async-reset sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;

  logic [31:0] mem [16];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[3:0]];

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  typedef struct {
    logic        pre_rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ei;
    logic [31:0] ea;
    logic        eh;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [31:0] wd(input int i);
    logic [31:0] k;
    k = 32'(i + 1);
    return 32'h2000_0000 | (k << 16) | k;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 16; i++) mem[i] = wd(i);
  endtask

  initial begin
    load_mem();
    tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  wd(0), 32'd1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h4,  wd(1), 32'd2, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h8,  wd(2), 32'd3, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hC,  wd(3), 32'd4, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  wd(0), 32'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  wd(0), 32'd2, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  wd(0), 32'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h0,  wd(0), 32'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h4,  wd(1), 32'd3, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h8,  wd(2), 32'd4, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'hC,  wd(3), 32'd5, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 32'h13, 1'b1, 1'b0, 32'h0,  32'h0, 32'd4, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h10, wd(4), 32'd5, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h14, wd(5), 32'd6, 1'b0};

    #2;
    chk("rst_valid",  32'(out_valid), 32'd0);
    chk("rst_instr",  out_instr, 32'h0);
    chk("rst_pc",     out_pc, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_addr",   imem_addr, 32'h0);
    #1;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].pre_rst) do_reset();
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      out_ready      = tbl[i].rdy;
      step();
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].ea);
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(tbl[i].eh));
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("v%0d_instr", i), out_instr, tbl[i].ei);
      end
    end

    // BREAK at word 2 halts fetch; redirect to 0 restarts
    do_reset();
    mem[2] = 32'h0000_000D;
    out_ready = 1'b1;
    step();
    chk("brk_pc0", out_pc, 32'h0);
    step();
    chk("brk_pc4", out_pc, 32'h4);
    step();
    chk("brk_pc8", out_pc, 32'h8);
    chk("brk_instr", out_instr, 32'h0000_000D);
    chk("brk_halted", 32'(halted), 32'd1);
    chk("brk_addr", imem_addr, 32'd3);
    step();
    chk("brk_drain_valid", 32'(out_valid), 32'd0);
    step();
    chk("brk_hold_addr", imem_addr, 32'd3);
    chk("brk_hold_halted", 32'(halted), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("brk_rd_halted", 32'(halted), 32'd0);
    chk("brk_rd_valid", 32'(out_valid), 32'd0);
    chk("brk_rd_addr", imem_addr, 32'd0);
    step();
    chk("brk_restart_valid", 32'(out_valid), 32'd1);
    chk("brk_restart_pc", out_pc, 32'h0);
    chk("brk_restart_instr", out_instr, wd(0));

    // Redirect on the same edge that would fetch the BREAK
    do_reset();
    out_ready = 1'b1;
    step();
    step();
    chk("rvb_addr", imem_addr, 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h4;
    step();
    redirect_valid = 1'b0;
    chk("rvb_halted", 32'(halted), 32'd0);
    chk("rvb_valid", 32'(out_valid), 32'd0);
    step();
    chk("rvb_halted2", 32'(halted), 32'd0);
    chk("rvb_pc", out_pc, 32'h4);
    chk("rvb_instr", out_instr, wd(1));

    // Async reset between edges with a full queue
    load_mem();
    do_reset();
    out_ready = 1'b0;
    step();
    step();
    chk("ar_full_addr", imem_addr, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_addr", imem_addr, 32'd0);
    chk("ar_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("ar_first_valid", 32'(out_valid), 32'd1);
    chk("ar_first_pc", out_pc, 32'h0);
    chk("ar_first_instr", out_instr, wd(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
